// File: rtl/dpdm_pkg.sv
// Shared DP/DM line-stage definitions: line states, packet-type codes,
// error codes and receive FSM states.
package dpdm_pkg;

   localparam int DLY    = 8;
   localparam int DLY_CW = $clog2(DLY + 1);
   localparam int DLY_AW = $clog2(DLY);

   // Line states as {dp, dm}
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_SE1 = 2'b11;

   // Packet-type codes, shared with the write side
   localparam logic [1:0] PT_NONE = 2'b00;
   localparam logic [1:0] PT_TOK  = 2'b01;
   localparam logic [1:0] PT_DATA = 2'b10;
   localparam logic [1:0] PT_HS   = 2'b11;

   localparam logic [1:0] ERR_SYNC = 2'b00;
   localparam logic [1:0] ERR_PID  = 2'b01;
   localparam logic [1:0] ERR_SE1  = 2'b10;
   localparam logic [1:0] ERR_LEN  = 2'b11;

   // dp levels of sync bits 0..7, read MSB first
   localparam logic [7:0] SYNC_PATTERN = 8'b0101_0100;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SYNC   = 3'd1,
      S_PID    = 3'd2,
      S_STREAM = 3'd3,
      S_EOP    = 3'd4,
      S_DRAIN  = 3'd5,
      S_ERR    = 3'd6
   } rx_state_t;

   // Packet type for a decoded PID; PT_NONE if the check nibble or type is bad
   function automatic logic [1:0] pid_ptype(input logic [7:0] pid);
      if (pid[7:4] != ~pid[3:0]) return PT_NONE;
      case (pid[1:0])
         2'b01:   return PT_TOK;
         2'b11:   return PT_DATA;
         2'b10:   return PT_HS;
         default: return PT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/dpdm_rx_if.sv
// Line-side inputs and unencoder-side outputs of the DP/DM receive stage.
interface dpdm_rx_if;
   logic       rx_en;
   logic       dp;
   logic       dm;
   logic       bstr;
   logic [1:0] bstr_ready;
   logic       pkt_done;
   logic       pkt_err;
   logic [1:0] err_code;
   logic       timeout;

   modport master (
      output rx_en, dp, dm,
      input  bstr, bstr_ready, pkt_done, pkt_err, err_code, timeout
   );

   modport slave (
      input  rx_en, dp, dm,
      output bstr, bstr_ready, pkt_done, pkt_err, err_code, timeout
   );
endinterface

// File: rtl/dpdm_rx_dly.sv
// 8-deep line-bit delay: new bits enter at sr[0], the oldest sits at sr[count-1].
module dpdm_rx_dly
   import dpdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic              din,
   output logic              dout,
   output logic [DLY_CW-1:0] count
);

   logic [DLY-1:0]    sr;
   logic [DLY_AW-1:0] top_idx;

   assign top_idx = DLY_AW'(count - 1'b1);
   assign dout    = (count == '0) ? 1'b0 : sr[top_idx];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush)
         count <= '0;
      else if (push && !pop && count != DLY_CW'(DLY))
         count <= count + 1'b1;
      else if (pop && !push && count != '0)
         count <= count - 1'b1;
   end

   // NOTE: the data shifter is not reset; occupancy alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push && !flush)
         sr <= {sr[DLY-2:0], din};
   end

endmodule

// File: rtl/dpdm_rx.sv
// DP/DM receive line stage: SYNC/PID qualification, fixed 8-bit delayed raw
// bit stream with packet-type tag, EOP/line-error checks and response timeout.
module dpdm_rx
   import dpdm_pkg::*;
#(
   parameter int MAX_BITS = 128,
   parameter int TIMEOUT  = 18
) (
   input logic     clk,
   input logic     rst,
   dpdm_rx_if.slave bus
);

   localparam int BW = $clog2(MAX_BITS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] MAX_L   = BW'(MAX_BITS);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

   rx_state_t state_q, state_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    pid_q, pid_d, pid_now;
   logic          prev_q, prev_d;
   logic [1:0]    ptype_q, ptype_d;
   logic          bstr_q, bstr_d;
   logic [1:0]    ready_q, ready_d;
   logic          done_q, done_d, err_q, err_d, tmo_pulse_q, tmo_pulse_d;
   logic [1:0]    code_q, code_d, err_sel;
   logic          err_hit, push, pop, flush, dly_dout;
   logic [DLY_CW-1:0] dly_count;
   logic [1:0]    line;

   assign line = {bus.dp, bus.dm};

   dpdm_rx_dly u_dly (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (bus.dp),
      .dout  (dly_dout),
      .count (dly_count)
   );

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path infers a latch.
      state_d = state_q;  bit_cnt_d = bit_cnt_q;  tmo_d = tmo_q;
      pid_d = pid_q;  pid_now = pid_q;  prev_d = prev_q;  ptype_d = ptype_q;
      push = 1'b0;  pop = 1'b0;  flush = 1'b0;
      bstr_d = 1'b0;  ready_d = PT_NONE;  done_d = 1'b0;  err_d = 1'b0;
      code_d = ERR_SYNC;  tmo_pulse_d = 1'b0;  err_hit = 1'b0;  err_sel = ERR_SYNC;

      unique case (state_q)
         S_IDLE: begin
            if (line == LS_K) begin
               state_d   = S_SYNC;
               bit_cnt_d = BW'(1);
               tmo_d     = TMO_MAX;  // a started packet disarms the timeout
            end else if (tmo_q != TMO_MAX) begin
               tmo_d       = tmo_q + 1'b1;
               tmo_pulse_d = (tmo_q == TMO_MAX - 1'b1);
            end
         end
         S_SYNC: begin
            if (line == LS_SE1) begin
               err_hit = 1'b1;  err_sel = ERR_SE1;
            end else if (line == LS_SE0 || bus.dp != SYNC_PATTERN[3'd7 - bit_cnt_q[2:0]]) begin
               err_hit = 1'b1;  err_sel = ERR_SYNC;
            end else if (bit_cnt_q[2:0] == 3'd7) begin
               state_d   = S_PID;
               bit_cnt_d = '0;
               prev_d    = bus.dp;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_PID: begin
            if (line == LS_SE1) begin
               err_hit = 1'b1;  err_sel = ERR_SE1;
            end else if (line == LS_SE0) begin
               err_hit = 1'b1;  err_sel = ERR_PID;
            end else begin
               push = 1'b1;
               pid_now[bit_cnt_q[2:0]] = ~(bus.dp ^ prev_q);
               pid_d     = pid_now;
               prev_d    = bus.dp;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q[2:0] == 3'd7) begin
                  if (pid_ptype(pid_now) == PT_NONE) begin
                     err_hit = 1'b1;  err_sel = ERR_PID;
                  end else begin
                     ptype_d = pid_ptype(pid_now);
                     state_d = S_STREAM;
                  end
               end
            end
         end
         S_STREAM: begin
            if (line == LS_SE1) begin
               err_hit = 1'b1;  err_sel = ERR_SE1;
            end else if (line == LS_SE0) begin
               pop = 1'b1;  bstr_d = dly_dout;  ready_d = ptype_q;
               state_d   = S_EOP;
               bit_cnt_d = '0;  // reused as the EOP step index
            end else if (bit_cnt_q == MAX_L) begin
               err_hit = 1'b1;  err_sel = ERR_LEN;
            end else begin
               push = 1'b1;  pop = 1'b1;  bstr_d = dly_dout;  ready_d = ptype_q;
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_EOP: begin
            pop = 1'b1;  bstr_d = dly_dout;  ready_d = ptype_q;
            if (!bit_cnt_q[0]) begin
               if (line != LS_SE0) begin
                  err_hit = 1'b1;  err_sel = ERR_SE1;
               end else begin
                  bit_cnt_d = BW'(1);
               end
            end else if (line != LS_J) begin
               err_hit = 1'b1;  err_sel = ERR_SE1;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (dly_count == '0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               pop = 1'b1;  bstr_d = dly_dout;  ready_d = ptype_q;
            end
         end
         S_ERR: begin
            if (line == LS_J) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (err_hit) begin
         state_d = S_ERR;  flush = 1'b1;  push = 1'b0;  pop = 1'b0;
         bstr_d = 1'b0;  ready_d = PT_NONE;  err_d = 1'b1;  code_d = err_sel;
      end

      // Dropping rx_en silently abandons whatever is in flight
      if (!bus.rx_en) begin
         state_d = S_IDLE;  flush = 1'b1;  push = 1'b0;  pop = 1'b0;
         bstr_d = 1'b0;  ready_d = PT_NONE;  done_d = 1'b0;  err_d = 1'b0;
         code_d = ERR_SYNC;  tmo_d = '0;  tmo_pulse_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;  bit_cnt_q <= '0;  tmo_q <= '0;
         pid_q <= '0;  prev_q <= 1'b0;  ptype_q <= PT_NONE;
         bstr_q <= 1'b0;  ready_q <= PT_NONE;  done_q <= 1'b0;
         err_q <= 1'b0;  code_q <= ERR_SYNC;  tmo_pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;  bit_cnt_q <= bit_cnt_d;  tmo_q <= tmo_d;
         pid_q <= pid_d;  prev_q <= prev_d;  ptype_q <= ptype_d;
         bstr_q <= bstr_d;  ready_q <= ready_d;  done_q <= done_d;
         err_q <= err_d;  code_q <= code_d;  tmo_pulse_q <= tmo_pulse_d;
      end
   end

   assign bus.bstr       = bstr_q;
   assign bus.bstr_ready = ready_q;
   assign bus.pkt_done   = done_q;
   assign bus.pkt_err    = err_q;
   assign bus.err_code   = code_q;
   assign bus.timeout    = tmo_pulse_q;

endmodule

// File: tb/tb_dpdm_rx.sv
// Directed bench for dpdm_rx: one line level per clock, outputs sampled 1ns after each edge.
module tb_dpdm_rx;

   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;
   localparam logic [1:0] SE1 = 2'b11;

   // Raw dp levels of PID bits 0..7, written MSB first
   localparam logic [7:0] ACK_DP  = 8'b1101_1000;  // decodes to 0xD2
   localparam logic [7:0] DATA_DP = 8'b0010_1000;  // decodes to 0xC3
   localparam logic [7:0] BAD_DP  = 8'b1101_1010;  // decodes to 0x12

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dpdm_rx_if bus ();

   dpdm_rx #(.MAX_BITS(128), .TIMEOUT(18)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int n_done, n_err, n_tmo;
   int done_cyc, err_cyc, tmo_cyc, first_cyc, last_cyc;
   int pid0, sync0, c1, mm;
   logic [1:0] last_code;
   logic [1:0] exp_type;
   logic q_bits[$];
   logic exp_bits[$];
   logic sdp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      n_done = 0;  n_err = 0;  n_tmo = 0;
      done_cyc = -1;  err_cyc = -1;  tmo_cyc = -1;  first_cyc = -1;  last_cyc = -1;
      last_code = 2'b00;
      q_bits.delete();
      exp_bits.delete();
   endtask

   task automatic tick(input logic [1:0] ls);
      bus.dp = ls[1];
      bus.dm = ls[0];
      @(posedge clk);
      #1;
      cyc++;
      if (bus.pkt_done === 1'b1) begin n_done++; done_cyc = cyc; end
      if (bus.pkt_err === 1'b1) begin n_err++; err_cyc = cyc; last_code = bus.err_code; end
      if (bus.timeout === 1'b1) begin n_tmo++; tmo_cyc = cyc; end
      if (bus.pkt_done === 1'b1 || bus.pkt_err === 1'b1)
         check("done_err_exclusive", {31'd0, bus.pkt_done & bus.pkt_err}, 32'd0);
      if (bus.bstr_ready !== 2'b00) begin
         if (q_bits.size() == 0) first_cyc = cyc;
         last_cyc = cyc;
         q_bits.push_back(bus.bstr);
         check("bstr_ready_type", {30'd0, bus.bstr_ready}, {30'd0, exp_type});
      end
   endtask

   task automatic send_sync(input int flip);
      logic [7:0] pat;
      logic b;
      pat = 8'b0101_0100;
      for (int i = 0; i < 8; i++) begin
         b = pat[7-i];
         if (i == flip) b = ~b;
         tick(b ? J : K);
      end
   endtask

   task automatic send_pid(input logic [7:0] dps);
      for (int i = 0; i < 8; i++) tick(dps[7-i] ? J : K);
   endtask

   function automatic logic [7:0] pack8();
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++)
         if (i < q_bits.size()) r[7-i] = q_bits[i];
      return r;
   endfunction

   initial begin
      rst = 1'b1;
      bus.rx_en = 1'b0;
      exp_type = 2'b11;
      clear_mon();
      repeat (3) tick(J);
      check("rst_bstr",       {31'd0, bus.bstr},       32'd0);
      check("rst_bstr_ready", {30'd0, bus.bstr_ready}, 32'd0);
      check("rst_pkt_done",   {31'd0, bus.pkt_done},   32'd0);
      check("rst_pkt_err",    {31'd0, bus.pkt_err},    32'd0);
      check("rst_err_code",   {30'd0, bus.err_code},   32'd0);
      check("rst_timeout",    {31'd0, bus.timeout},    32'd0);
      rst = 1'b0;

      // ACK handshake
      clear_mon();
      exp_type = 2'b11;
      bus.rx_en = 1'b1;
      repeat (4) tick(J);
      send_sync(-1);
      pid0 = cyc + 1;
      send_pid(ACK_DP);
      tick(SE0);
      tick(SE0);
      tick(J);
      repeat (8) tick(J);
      check("ack_nbits",   q_bits.size(), 32'd8);
      check("ack_bits",    {24'd0, pack8()}, {24'd0, ACK_DP});
      check("ack_latency", first_cyc, pid0 + 8);
      check("ack_done_n",  n_done, 32'd1);
      check("ack_done_at", done_cyc, last_cyc + 1);
      check("ack_err_n",   n_err, 32'd0);
      check("ack_tmo_n",   n_tmo, 32'd0);

      // SYNC bit 5 flipped; following K bits must not restart SYNC from ERR
      clear_mon();
      repeat (2) tick(J);
      sync0 = cyc + 1;
      send_sync(5);
      repeat (3) tick(J);
      check("sync_err_n",    n_err, 32'd1);
      check("sync_err_code", {30'd0, last_code}, 32'd0);
      check("sync_err_at",   err_cyc, sync0 + 5);
      check("sync_nbits",    q_bits.size(), 32'd0);
      check("sync_done_n",   n_done, 32'd0);

      // PID check nibble wrong
      clear_mon();
      repeat (2) tick(J);
      send_sync(-1);
      pid0 = cyc + 1;
      send_pid(BAD_DP);
      repeat (3) tick(J);
      check("pid_err_n",    n_err, 32'd1);
      check("pid_err_code", {30'd0, last_code}, 32'd1);
      check("pid_err_at",   err_cyc, pid0 + 7);
      check("pid_nbits",    q_bits.size(), 32'd0);
      check("pid_done_n",   n_done, 32'd0);

      // DATA packet with no EOP: bit 129 after SYNC aborts with LEN
      clear_mon();
      exp_type = 2'b10;
      repeat (2) tick(J);
      send_sync(-1);
      pid0 = cyc + 1;
      for (int i = 0; i < 8; i++) exp_bits.push_back(DATA_DP[7-i]);
      send_pid(DATA_DP);
      for (int k = 1; k <= 121; k++) begin
         sdp = k[0] ^ k[3];
         if (k <= 112) exp_bits.push_back(sdp);
         tick(sdp ? J : K);
      end
      repeat (4) tick(J);
      mm = 0;
      for (int i = 0; i < q_bits.size() && i < exp_bits.size(); i++)
         if (q_bits[i] !== exp_bits[i]) mm++;
      check("len_nbits",    q_bits.size(), 32'd120);
      check("len_bits_mm",  mm, 32'd0);
      check("len_err_n",    n_err, 32'd1);
      check("len_err_code", {30'd0, last_code}, 32'd3);
      check("len_err_at",   err_cyc, pid0 + 128);
      check("len_done_n",   n_done, 32'd0);

      // Timeout: rx_en re-armed, line idle J for 40 cycles
      clear_mon();
      bus.rx_en = 1'b0;
      repeat (2) tick(J);
      bus.rx_en = 1'b1;
      c1 = cyc + 1;
      repeat (40) tick(J);
      check("tmo_n",  n_tmo, 32'd1);
      check("tmo_at", tmo_cyc, c1 + 17);

      // rx_en dropped mid-STREAM
      clear_mon();
      exp_type = 2'b10;
      tick(J);
      send_sync(-1);
      send_pid(DATA_DP);
      tick(K);
      tick(J);
      tick(K);
      bus.rx_en = 1'b0;
      tick(K);
      check("abort_ready", {30'd0, bus.bstr_ready}, 32'd0);
      bus.rx_en = 1'b1;
      repeat (4) tick(J);
      check("abort_nbits",  q_bits.size(), 32'd3);
      check("abort_done_n", n_done, 32'd0);
      check("abort_err_n",  n_err, 32'd0);

      // SE1 mid-STREAM
      clear_mon();
      send_sync(-1);
      send_pid(DATA_DP);
      tick(K);
      tick(J);
      tick(SE1);
      check("se1_ready", {30'd0, bus.bstr_ready}, 32'd0);
      repeat (3) tick(J);
      check("se1_err_n",    n_err, 32'd1);
      check("se1_err_code", {30'd0, last_code}, 32'd2);
      check("se1_nbits",    q_bits.size(), 32'd2);
      check("se1_done_n",   n_done, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
